// File: rtl/vrf_cfg_masked_if.sv
// Handshake/data bundle between vector decode/execute, writeback and vrf_cfg_masked.
// Purely combinational signal grouping; the register file never back-pressures beyond ready.
interface vrf_cfg_masked_if #(
  parameter int VLEN  = 64,
  parameter int NREGS = 32,
  parameter int XLEN  = 32
);
  localparam int AW  = $clog2(NREGS);
  localparam int VLW = $clog2(VLEN / 8) + 1;

  logic            ready;
  logic            clr_req;
  logic [AW-1:0]   raA;
  logic [AW-1:0]   raB;
  logic [VLEN-1:0] rdA;
  logic [VLEN-1:0] rdB;
  logic [VLEN-1:0] rd_mask;
  logic            wen;
  logic [AW-1:0]   wa;
  logic [VLEN-1:0] wd;
  logic            vm;
  logic            wwhole;
  logic            cfg_we;
  logic [XLEN-1:0] avl_in;
  logic [1:0]      vsew_in;
  logic [VLW-1:0]  vl;
  logic [VLW-1:0]  vlmax;
  logic [1:0]      vsew;
  logic            vill;

  modport slave (
    input  clr_req, raA, raB, wen, wa, wd, vm, wwhole, cfg_we, avl_in, vsew_in,
    output ready, rdA, rdB, rd_mask, vl, vlmax, vsew, vill
  );

  modport master (
    output clr_req, raA, raB, wen, wa, wd, vm, wwhole, cfg_we, avl_in, vsew_in,
    input  ready, rdA, rdB, rd_mask, vl, vlmax, vsew, vill
  );
endinterface

// File: rtl/vrf_cfg_masked.sv
// Vector register file with vsetvl state, vl/SEW/v0-masked element writes and post-reset init.
// Reads/bypass are zero-latency, writes and config commit on clk; writes/config ignored until ready.
module vrf_cfg_masked #(
  parameter int              VLEN     = 64,
  parameter int              NREGS    = 32,
  parameter int              ELEN     = 64,
  parameter int              XLEN     = 32,
  parameter logic [VLEN-1:0] INIT_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  vrf_cfg_masked_if.slave  bus
);
  localparam int AW  = $clog2(NREGS);
  localparam int VLW = $clog2(VLEN / 8) + 1;
  localparam int LBW = $clog2(VLEN);

  typedef enum logic [1:0] {S_RST, S_INIT, S_READY} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [VLW-1:0]  vl_q, vl_d;
  logic [VLW-1:0]  vlmax_q, vlmax_d;
  logic [1:0]      vsew_q, vsew_d;
  logic            vill_q, vill_d;
  logic [VLEN-1:0] mem_q [NREGS];

  logic            ready;
  logic            wr_act;
  logic [VLEN-1:0] wr_old;
  logic [VLEN-1:0] v0_old;
  logic [VLEN-1:0] en_bits;
  logic [VLEN-1:0] merged;
  logic [LBW-1:0]  ei;
  logic [VLW-1:0]  vlmax_new;

  assign ready  = (state_q == S_READY);
  assign wr_act = bus.wen && ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RST;
      idx_q   <= '0;
      vl_q    <= '0;
      vlmax_q <= VLW'(VLEN / 8);
      vsew_q  <= '0;
      vill_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vl_q    <= vl_d;
      vlmax_q <= vlmax_d;
      vsew_q  <= vsew_d;
      vill_q  <= vill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_RST: begin
        state_d = S_INIT;
        idx_d   = '0;
      end
      S_INIT: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == AW'(NREGS - 1)) state_d = S_READY;
      end
      S_READY: begin
        if (bus.clr_req) begin
          state_d = S_INIT;
          idx_d   = '0;
        end
      end
      default: state_d = S_RST;
    endcase
  end

  // Storage is deliberately not reset; the init sequencer fills it instead.
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) mem_q[idx_q] <= INIT_VAL;
    else if (wr_act)       mem_q[bus.wa] <= merged;
  end

  always_comb begin
    vlmax_new = VLW'(VLEN >> (3 + int'(bus.vsew_in)));
    vl_d      = vl_q;
    vlmax_d   = vlmax_q;
    vsew_d    = vsew_q;
    vill_d    = vill_q;
    if (bus.cfg_we && ready) begin
      vsew_d  = bus.vsew_in;
      vlmax_d = vlmax_new;
      if ((8 << int'(bus.vsew_in)) > ELEN) begin
        vill_d = 1'b1;
        vl_d   = '0;
      end else begin
        vill_d = 1'b0;
        vl_d   = (bus.avl_in < XLEN'(vlmax_new)) ? VLW'(bus.avl_in) : vlmax_new;
      end
    end
  end

  // Per-bit enable: bit b belongs to element b>>log2(SEW), gated by vl and the pre-write v0.
  always_comb begin
    wr_old  = mem_q[bus.wa];
    v0_old  = mem_q[0];
    en_bits = '0;
    ei      = '0;
    for (int b = 0; b < VLEN; b++) begin
      ei         = LBW'(b >> (3 + int'(vsew_q)));
      en_bits[b] = (ei < LBW'(vl_q)) && (bus.vm || v0_old[ei]);
    end
    if (bus.wwhole)  merged = bus.wd;
    else if (vill_q) merged = wr_old;
    else             merged = (wr_old & ~en_bits) | (bus.wd & en_bits);
  end

  assign bus.ready   = ready;
  assign bus.rdA     = !ready ? '0 : (wr_act && bus.wa == bus.raA) ? merged : mem_q[bus.raA];
  assign bus.rdB     = !ready ? '0 : (wr_act && bus.wa == bus.raB) ? merged : mem_q[bus.raB];
  assign bus.rd_mask = !ready ? '0 : (wr_act && bus.wa == '0)      ? merged : mem_q[0];
  assign bus.vl      = vl_q;
  assign bus.vlmax   = vlmax_q;
  assign bus.vsew    = vsew_q;
  assign bus.vill    = vill_q;
endmodule

// File: tb/tb_vrf_cfg_masked.sv
// Directed bench for vrf_cfg_masked: one ELEN=64 instance and one ELEN=32 instance.
module tb_vrf_cfg_masked;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  vrf_cfg_masked_if #(.VLEN(64), .NREGS(32), .XLEN(32)) bus0 ();
  vrf_cfg_masked_if #(.VLEN(64), .NREGS(32), .XLEN(32)) bus1 ();

  vrf_cfg_masked #(.VLEN(64), .NREGS(32), .ELEN(64), .XLEN(32), .INIT_VAL('0)) u_dut (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  vrf_cfg_masked #(.VLEN(64), .NREGS(32), .ELEN(32), .XLEN(32), .INIT_VAL('0)) u_dut32 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic idle_bus(input bit sel);
    if (sel) begin
      bus1.clr_req = 0; bus1.raA = '0; bus1.raB = '0; bus1.wen = 0; bus1.wa = '0; bus1.wd = '0;
      bus1.vm = 1; bus1.wwhole = 0; bus1.cfg_we = 0; bus1.avl_in = '0; bus1.vsew_in = '0;
    end else begin
      bus0.clr_req = 0; bus0.raA = '0; bus0.raB = '0; bus0.wen = 0; bus0.wa = '0; bus0.wd = '0;
      bus0.vm = 1; bus0.wwhole = 0; bus0.cfg_we = 0; bus0.avl_in = '0; bus0.vsew_in = '0;
    end
  endtask

  task automatic cfg(input bit sel, input logic [31:0] avl, input logic [1:0] sew,
                     input int exp_vl, input int exp_vlmax, input logic exp_vill);
    @(negedge clk);
    if (sel) begin bus1.cfg_we = 1; bus1.avl_in = avl; bus1.vsew_in = sew; end
    else     begin bus0.cfg_we = 1; bus0.avl_in = avl; bus0.vsew_in = sew; end
    @(negedge clk);
    bus0.cfg_we = 0; bus1.cfg_we = 0;
    #1;
    if (sel) begin
      chk("cfg_vl", 64'(bus1.vl), 64'(exp_vl));
      chk("cfg_vlmax", 64'(bus1.vlmax), 64'(exp_vlmax));
      chk("cfg_vill", 64'(bus1.vill), 64'(exp_vill));
      chk("cfg_vsew", 64'(bus1.vsew), 64'(sew));
    end else begin
      chk("cfg_vl", 64'(bus0.vl), 64'(exp_vl));
      chk("cfg_vlmax", 64'(bus0.vlmax), 64'(exp_vlmax));
      chk("cfg_vill", 64'(bus0.vill), 64'(exp_vill));
      chk("cfg_vsew", 64'(bus0.vsew), 64'(sew));
    end
  endtask

  // Drives one write, checks the bypassed value in the same cycle and the stored value after.
  task automatic wr(input bit sel, input logic [4:0] a, input logic [63:0] d, input logic m,
                    input logic whole, input logic [63:0] exp);
    @(negedge clk);
    if (sel) begin
      bus1.wen = 1; bus1.wa = a; bus1.wd = d; bus1.vm = m; bus1.wwhole = whole; bus1.raA = a;
    end else begin
      bus0.wen = 1; bus0.wa = a; bus0.wd = d; bus0.vm = m; bus0.wwhole = whole; bus0.raA = a;
    end
    #1;
    chk("wr_bypass", sel ? bus1.rdA : bus0.rdA, exp);
    if (a == 5'd0) chk("mask_bypass", sel ? bus1.rd_mask : bus0.rd_mask, exp);
    @(negedge clk);
    bus0.wen = 0; bus1.wen = 0; bus0.wwhole = 0; bus1.wwhole = 0; bus0.vm = 1; bus1.vm = 1;
    #1;
    chk("wr_stored", sel ? bus1.rdA : bus0.rdA, exp);
  endtask

  task automatic rd(input bit sel, input logic [4:0] a, input logic [63:0] exp, input string tag);
    @(negedge clk);
    if (sel) bus1.raA = a; else bus0.raA = a;
    #1;
    chk(tag, sel ? bus1.rdA : bus0.rdA, exp);
  endtask

  initial begin
    int n;
    idle_bus(0);
    idle_bus(1);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 64'(bus0.ready), 64'd0);
    chk("rst_vill", 64'(bus0.vill), 64'd1);
    chk("rst_vl", 64'(bus0.vl), 64'd0);
    chk("rst_vlmax", 64'(bus0.vlmax), 64'd8);
    chk("rst_rd_zero", bus0.rdA, 64'd0);

    @(negedge clk);
    rst = 1;
    n = 0;
    while (!bus0.ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ready_edges", 64'(n), 64'd33);
    chk("ready_elen32", 64'(bus1.ready), 64'd1);

    for (int i = 0; i < 32; i++) rd(0, 5'(i), 64'd0, "init_zero");
    chk("post_init_vill", 64'(bus0.vill), 64'd1);
    chk("post_init_vl", 64'(bus0.vl), 64'd0);

    cfg(0, 32'd5, 2'd1, 4, 4, 1'b0);
    cfg(0, 32'd3, 2'd0, 3, 8, 1'b0);
    cfg(0, 32'hFFFF_FFFF, 2'd3, 1, 1, 1'b0);
    cfg(0, 32'd3, 2'd0, 3, 8, 1'b0);

    wr(0, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'h0000_0000_00FF_FFFF);
    wr(0, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    wr(0, 5'd1, 64'h0, 1'b1, 1'b0, 64'hFFFF_FFFF_FF00_0000);

    bus0.raB = 5'd4;
    wr(0, 5'd3, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 1'b0, 64'h0000_0000_00AA_AAAA);
    chk("rdB_unaffected", bus0.rdB, 64'd0);

    wr(0, 5'd0, 64'h0000_0000_0000_0005, 1'b1, 1'b1, 64'h0000_0000_0000_0005);
    cfg(0, 32'd8, 2'd0, 8, 8, 1'b0);
    wr(0, 5'd2, 64'h1111_1111_1111_1111, 1'b0, 1'b0, 64'h0000_0000_0011_0011);
    cfg(0, 32'd8, 2'd1, 4, 4, 1'b0);
    wr(0, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'h0000_FFFF_0000_FFFF);
    cfg(0, 32'd2, 2'd1, 2, 4, 1'b0);
    wr(0, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF);

    // Same-cycle config: merge must still use SEW=16, vl=2.
    bus0.avl_in = 32'd8; bus0.vsew_in = 2'd0;
    @(negedge clk);
    bus0.cfg_we = 1;
    bus0.wen = 1; bus0.wa = 5'd6; bus0.wd = '1; bus0.vm = 1; bus0.raA = 5'd6;
    @(negedge clk);
    bus0.cfg_we = 0; bus0.wen = 0;
    #1;
    chk("samecyc_data", bus0.rdA, 64'h0000_0000_FFFF_FFFF);
    chk("samecyc_vl", 64'(bus0.vl), 64'd8);
    chk("samecyc_vsew", 64'(bus0.vsew), 64'd0);

    chk("e32_vill_init", 64'(bus1.vill), 64'd1);
    wr(1, 5'd7, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b1, 64'h0123_4567_89AB_CDEF);
    cfg(1, 32'd4, 2'd3, 0, 1, 1'b1);
    wr(1, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF);
    cfg(1, 32'd4, 2'd2, 2, 2, 1'b0);

    @(negedge clk);
    bus0.raA = 5'd1;
    bus0.clr_req = 1;
    @(negedge clk);
    bus0.clr_req = 0;
    #1;
    chk("clr_ready_low", 64'(bus0.ready), 64'd0);
    chk("clr_rd_zero", bus0.rdA, 64'd0);
    n = 0;
    while (!bus0.ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("clr_edges", 64'(n), 64'd32);
    for (int i = 0; i < 32; i++) rd(0, 5'(i), 64'd0, "clr_zero");
    chk("clr_cfg_kept", 64'(bus0.vl), 64'd8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/vrf_cfg_masked.md
# vrf_cfg_masked

Parametrised vector register file with an integrated vector-configuration (vsetvl) unit. It applies per-element write enables derived from vl, SEW and the v0 mask, and runs a post-reset initialisation sequencer. The block sits between the vector decode/execute stages and writeback. It provides two bypassed operand read ports, a dedicated v0 mask port, and the architectural vl/vtype state consumed by the vector ALU.

## Interface

Parameters:
- VLEN, 64: bits per vector register; power of two, at least 32.
- NREGS, 32: number of vector registers; power of two.
- ELEN, 64: maximum legal SEW in bits (32 or 64).
- XLEN, 32: width of the AVL input.
- INIT_VAL, 0: value written to every register by the init sequencer.
- Derived: AW = log2(NREGS); VLW = log2(VLEN/8)+1.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-low.
- ready, output, 1: register file initialised and accepting writes.
- clr_req, input, 1: soft re-initialisation request, sampled only while ready=1.
- raA, raB, input, AW: read addresses.
- rdA, rdB, output, VLEN: read data, bypassed.
- rd_mask, output, VLEN: contents of v0, bypassed.
- wen, input, 1: write strobe.
- wa, input, AW: write address.
- wd, input, VLEN: write data.
- vm, input, 1: 1 = unmasked; 0 = element i is written only if v0[i]=1.
- wwhole, input, 1: whole-register write; ignores vl, mask and vill.
- cfg_we, input, 1: vsetvl strobe.
- avl_in, input, XLEN: requested application vector length.
- vsew_in, input, 2: 0=8, 1=16, 2=32, 3=64 bits.
- vl, output, VLW: current vector length.
- vlmax, output, VLW: VLEN/SEW for the current SEW.
- vsew, output, 2: current SEW code.
- vill, output, 1: illegal configuration flag.

## Operation

**Init FSM** (states RST, INIT, READY):
- Async reset forces RST: idx=0, ready=0, vl=0, vsew=0, vill=1, vlmax=VLEN/8. Register storage is not reset.
- RST goes to INIT on the first clock after rst is released.
- INIT writes INIT_VAL to register idx, then increments idx. After the write to idx=NREGS-1 the FSM moves to READY.
- In READY, clr_req=1 returns the FSM to INIT with idx=0 and ready=0.
- Reset asserted mid-INIT aborts the sequence; it restarts from idx=0 after release.
- While ready=0: wen is ignored, rdA, rdB and rd_mask read 0, and cfg_we is ignored.

**Config unit** (acts when cfg_we=1 and ready=1):
- If SEW(vsew_in) > ELEN: vill=1, vl=0, vsew=vsew_in, vlmax=VLEN/SEW.
- Otherwise: vill=0, vsew=vsew_in, vlmax=VLEN/SEW, and vl = min(avl_in, vlmax) compared at full XLEN width.

**Write merge** (acts when wen=1 and ready=1):
- Element i, for i in 0..VLEN/SEW-1, covers bits [i*SEW +: SEW].
- Element i is written iff i < vl, vill=0, and (vm=1 or v0[i]=1).
- v0 is the stored v0, before the current write.
- Elements that are not written keep their old value (tail and mask undisturbed).
- If vill=1 and wwhole=0, the write is suppressed.
- If wwhole=1, all VLEN bits are written.
- A cfg_we in the same cycle does not affect the merge; the merge uses the old vl/vsew.

**Bypass:**
- If wen=1, ready=1 and wa==raX, rdX returns the merged value instead of the stored value.
- If wa==0, rd_mask returns the merged value.

## Timing

- Reads are combinational; there is zero-cycle latency through the bypass.
- A write commits at the clk edge and is visible from storage on the next cycle.
- Config commits at the clk edge; vl, vsew, vill and vlmax update the following cycle.
- ready rises exactly NREGS+1 rising edges after rst is released: one edge for RST to INIT, then NREGS init writes.
- After clr_req, ready is low for NREGS cycles and high again on the edge after the last init write.
- Simultaneous wen and clr_req in READY: the write commits, then the register is overwritten by INIT.

## Test plan

- Reset hold, release: ready=0 for 33 edges, then ready=1. Then all 32 registers read INIT_VAL=0, vill=1 and vl=0.
- cfg avl=5, vsew=1 gives vl=4, vlmax=4, vill=0. Then avl=3, vsew=0 gives vl=3, vlmax=8. Then avl=0xFFFFFFFF, vsew=3 gives vl=1.
- vsew=0, vl=3, vm=1, write 0xFFFFFFFFFFFFFFFF to v1 (holding 0) gives v1=0x0000000000FFFFFF. The same write with wwhole=1 gives all ones.
- v0=0x05, vsew=0, vl=8, vm=0, write 0x1111111111111111 to v2 (holding 0) gives v2=0x0000000000110011.
- Bypass: wen to v3 with raA=3 makes rdA show the merged value in the same cycle. Writing v0 with wwhole=1 makes rd_mask show wd in the same cycle.
- ELEN=32: cfg vsew=3 gives vill=1, vl=0, and a following non-whole write leaves its target unchanged. clr_req in READY drops ready for 32 cycles and all registers read 0 afterwards.
